// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
//   lsu_op_t     : 4-bit load/store operation code carried in EX/MEM.
//   mem_state_t  : state of the data-memory transaction FSM.
//   decode_op    : maps raw op codes onto lsu_op_t (unknown -> NONE).
//   is_load/is_store/is_misaligned : op classification helpers.
package mem_stage_pkg;

    localparam logic RST_VALID = 1'b1;

    typedef enum logic [3:0] {
        LSU_OP_NONE  = 4'd0,
        LSU_OP_LD_B  = 4'd1,
        LSU_OP_LD_H  = 4'd2,
        LSU_OP_LD_W  = 4'd3,
        LSU_OP_LD_BU = 4'd4,
        LSU_OP_LD_HU = 4'd5,
        LSU_OP_ST_B  = 4'd6,
        LSU_OP_ST_H  = 4'd7,
        LSU_OP_ST_W  = 4'd8
    } lsu_op_t;

    localparam lsu_op_t LSU_OP_INVALID = LSU_OP_NONE;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2,
        MS_DONE = 2'd3
    } mem_state_t;

    function automatic lsu_op_t decode_op(input logic [3:0] code);
        lsu_op_t op;
        case (code)
            4'd1:    op = LSU_OP_LD_B;
            4'd2:    op = LSU_OP_LD_H;
            4'd3:    op = LSU_OP_LD_W;
            4'd4:    op = LSU_OP_LD_BU;
            4'd5:    op = LSU_OP_LD_HU;
            4'd6:    op = LSU_OP_ST_B;
            4'd7:    op = LSU_OP_ST_H;
            4'd8:    op = LSU_OP_ST_W;
            default: op = LSU_OP_INVALID;
        endcase
        return op;
    endfunction

    function automatic logic is_load(input lsu_op_t op);
        logic r;
        case (op)
            LSU_OP_LD_B, LSU_OP_LD_H, LSU_OP_LD_W,
            LSU_OP_LD_BU, LSU_OP_LD_HU: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input lsu_op_t op);
        logic r;
        case (op)
            LSU_OP_ST_B, LSU_OP_ST_H, LSU_OP_ST_W: r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

    // Halfword ops need ea[0]==0, word ops need ea[1:0]==0.
    function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] off);
        logic r;
        case (op)
            LSU_OP_LD_H, LSU_OP_LD_HU, LSU_OP_ST_H: r = off[0];
            LSU_OP_LD_W, LSU_OP_ST_W:               r = (off != 2'b00);
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage (request/grant/response).
//   req/we/addr/wstrb/wdata : request side, driven by the stage (master).
//   gnt                     : request accepted this cycle.
//   rvalid/rdata            : load response.
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wstrb;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wstrb, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wstrb, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic for the memory stage.
//   op/offset   : decoded lsu op and effective-address byte offset.
//   store_data  : raw store operand -> wstrb/wdata (lane-replicated).
//   load_word   : captured memory word -> load_data (aligned, extended).
module mem_stage_lsu_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  lsu_op_t           op,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] load_word,
    output logic [3:0]        wstrb,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data
);

    logic [DATA_W-1:0] shifted_s;

    // Bring the addressed byte/halfword down to bit 0.
    assign shifted_s = load_word >> {offset, 3'b000};

    // Store strobes and byte-lane replication.
    always_comb begin
        wstrb = 4'b0000;
        wdata = store_data;
        case (op)
            LSU_OP_ST_B: begin
                wstrb = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            LSU_OP_ST_H: begin
                wstrb = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            LSU_OP_ST_W: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: begin
                wstrb = 4'b0000;
                wdata = store_data;
            end
        endcase
    end

    // Load extraction with sign or zero extension.
    always_comb begin
        load_data = load_word;
        case (op)
            LSU_OP_LD_B:  load_data = {{(DATA_W-8){shifted_s[7]}}, shifted_s[7:0]};
            LSU_OP_LD_BU: load_data = {{(DATA_W-8){1'b0}}, shifted_s[7:0]};
            LSU_OP_LD_H:  load_data = {{(DATA_W-16){shifted_s[15]}}, shifted_s[15:0]};
            LSU_OP_LD_HU: load_data = {{(DATA_W-16){1'b0}}, shifted_s[15:0]};
            LSU_OP_LD_W:  load_data = load_word;
            default:      load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX/MEM and MEM/WB.
//   clk, rst          : clock, synchronous active-high reset.
//   mem_*             : EX/MEM record (inst, pc, ex_result, rw_en, rw_addr, lsu_data, lsu_op).
//   dmem              : data-memory port (mem_stage_if master).
//   wb_*              : record for MEM/WB, valid when wb_valid=1.
//   stall_req         : hold EX/MEM and earlier stages.
//   ale               : misaligned-address exception for the current op.
// Non-memory ops pass through combinationally; aligned load/store ops run
// IDLE -> REQ -> (WAIT) -> DONE and present the record once in DONE.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_inst,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic [DATA_W-1:0] mem_ex_result,
    input  logic              mem_rw_en,
    input  logic [REG_AW-1:0] mem_rw_addr,
    input  logic [DATA_W-1:0] mem_lsu_data,
    input  logic [3:0]        mem_lsu_op,
    mem_stage_if.master       dmem,
    output logic              wb_valid,
    output logic [31:0]       wb_inst,
    output logic [ADDR_W-1:0] wb_pc,
    output logic              wb_rw_en,
    output logic [REG_AW-1:0] wb_rw_addr,
    output logic [DATA_W-1:0] wb_rw_data,
    output logic              stall_req,
    output logic              ale
);

    mem_state_t        state_r;
    mem_state_t        next_s;
    logic [DATA_W-1:0] rdata_r;
    lsu_op_t           op_s;
    logic              is_mem_s;
    logic              misaligned_s;
    logic              run_s;
    logic [DATA_W-1:0] ld_data_s;
    logic              stall_s;
    logic              req_s;
    logic              we_s;
    logic              wb_valid_s;
    logic              wb_rw_en_s;
    logic [DATA_W-1:0] wb_rw_data_s;
    logic              ale_s;

    assign op_s         = decode_op(mem_lsu_op);
    assign is_mem_s     = (op_s != LSU_OP_NONE);
    assign misaligned_s = is_misaligned(op_s, mem_ex_result[1:0]);
    assign run_s        = (rst != RST_VALID);

    mem_stage_lsu_align #(.DATA_W(DATA_W)) u_align (
        .op         (op_s),
        .offset     (mem_ex_result[1:0]),
        .store_data (mem_lsu_data),
        .load_word  (rdata_r),
        .wstrb      (dmem.wstrb),
        .wdata      (dmem.wdata),
        .load_data  (ld_data_s)
    );

    // State register and load-data capture (only accepted in WAIT).
    always_ff @(posedge clk) begin
        if (rst == RST_VALID) begin
            state_r <= MS_IDLE;
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= next_s;
            if ((state_r == MS_WAIT) && dmem.rvalid) begin
                rdata_r <= dmem.rdata;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        next_s       = state_r;
        stall_s      = 1'b0;
        req_s        = 1'b0;
        we_s         = 1'b0;
        wb_valid_s   = 1'b0;
        wb_rw_en_s   = 1'b0;
        wb_rw_data_s = mem_ex_result;
        ale_s        = 1'b0;
        case (state_r)
            MS_IDLE: begin
                if (!is_mem_s) begin
                    wb_valid_s = 1'b1;
                    wb_rw_en_s = mem_rw_en;
                end else if (misaligned_s) begin
                    // Exception travels to WB instead of touching memory.
                    wb_valid_s = 1'b1;
                    ale_s      = 1'b1;
                end else begin
                    stall_s = 1'b1;
                    next_s  = MS_REQ;
                end
            end
            MS_REQ: begin
                stall_s = 1'b1;
                req_s   = 1'b1;
                we_s    = is_store(op_s);
                if (dmem.gnt) begin
                    next_s = is_store(op_s) ? MS_DONE : MS_WAIT;
                end else begin
                    next_s = MS_REQ;
                end
            end
            MS_WAIT: begin
                stall_s = 1'b1;
                if (dmem.rvalid) begin
                    next_s = MS_DONE;
                end else begin
                    next_s = MS_WAIT;
                end
            end
            MS_DONE: begin
                wb_valid_s   = 1'b1;
                wb_rw_en_s   = is_store(op_s) ? 1'b0 : mem_rw_en;
                wb_rw_data_s = is_load(op_s) ? ld_data_s : mem_ex_result;
                next_s       = MS_IDLE;
            end
            default: begin
                next_s = MS_IDLE;
            end
        endcase
    end

    // Control outputs are forced low while reset is asserted.
    assign stall_req  = stall_s & run_s;
    assign dmem.req   = req_s & run_s;
    assign dmem.we    = we_s & run_s;
    assign dmem.addr  = {mem_ex_result[ADDR_W-1:2], 2'b00};
    assign wb_valid   = wb_valid_s & run_s;
    assign wb_rw_en   = wb_rw_en_s & run_s;
    assign ale        = ale_s & run_s;
    assign wb_rw_data = wb_rw_data_s;
    assign wb_inst    = mem_inst;
    assign wb_pc      = mem_pc;
    assign wb_rw_addr = mem_rw_addr;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of ops with a small memory
// responder, a scoreboard of expected WB records, and hand-written reset
// sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_inst = 32'd0;
    logic [31:0] mem_pc = 32'd0;
    logic [31:0] mem_ex_result = 32'd0;
    logic        mem_rw_en = 1'b0;
    logic [4:0]  mem_rw_addr = 5'd0;
    logic [31:0] mem_lsu_data = 32'd0;
    logic [3:0]  mem_lsu_op = 4'd0;
    logic        wb_valid;
    logic [31:0] wb_inst;
    logic [31:0] wb_pc;
    logic        wb_rw_en;
    logic [4:0]  wb_rw_addr;
    logic [31:0] wb_rw_data;
    logic        stall_req;
    logic        ale;

    mem_stage_if #(.ADDR_W(32), .DATA_W(32)) dmem ();

    mem_stage #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_inst      (mem_inst),
        .mem_pc        (mem_pc),
        .mem_ex_result (mem_ex_result),
        .mem_rw_en     (mem_rw_en),
        .mem_rw_addr   (mem_rw_addr),
        .mem_lsu_data  (mem_lsu_data),
        .mem_lsu_op    (mem_lsu_op),
        .dmem          (dmem),
        .wb_valid      (wb_valid),
        .wb_inst       (wb_inst),
        .wb_pc         (wb_pc),
        .wb_rw_en      (wb_rw_en),
        .wb_rw_addr    (wb_rw_addr),
        .wb_rw_data    (wb_rw_data),
        .stall_req     (stall_req),
        .ale           (ale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] ea;
        logic [31:0] sdata;
        logic        rw_en;
        logic [4:0]  rw_addr;
        int          gd;
        int          rd;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_rw_en;
        logic        exp_ale;
        int          exp_stall;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        rw_en;
        logic        ale;
        logic [4:0]  rw_addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        chk_data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[16];
    vec_t vr;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] ea, input logic [31:0] sdata,
                                input logic rw_en, input logic [4:0] rw_addr, input int gd, input int rd,
                                input logic [31:0] rdata, input logic [31:0] exp_data, input logic exp_rw_en,
                                input logic exp_ale, input int exp_stall, input logic exp_req, input logic exp_we,
                                input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata, input logic chk_data);
        vec_t v;
        v.op = op; v.ea = ea; v.sdata = sdata; v.rw_en = rw_en; v.rw_addr = rw_addr;
        v.gd = gd; v.rd = rd; v.rdata = rdata; v.exp_data = exp_data; v.exp_rw_en = exp_rw_en;
        v.exp_ale = exp_ale; v.exp_stall = exp_stall; v.exp_req = exp_req; v.exp_we = exp_we;
        v.exp_wstrb = exp_wstrb; v.exp_wdata = exp_wdata; v.chk_data = chk_data;
        return v;
    endfunction

    // Scoreboard: every WB record the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        if (rst == 1'b0 && wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got wb_valid=1 pc=0x%08h want no record", wb_pc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_rw_en", 32'(wb_rw_en), 32'(mon_e.rw_en));
                chk("ale", 32'(ale), 32'(mon_e.ale));
                chk("wb_rw_addr", 32'(wb_rw_addr), 32'(mon_e.rw_addr));
                chk("wb_pc", wb_pc, mon_e.pc);
                chk("wb_inst", wb_inst, mon_e.inst);
                if (mon_e.chk_data) begin
                    chk("wb_rw_data", wb_rw_data, mon_e.data);
                end
            end
        end
    end

    task automatic drive(input vec_t v, input int idx, input bit push);
        exp_t e;
        mem_lsu_op    = v.op;
        mem_ex_result = v.ea;
        mem_lsu_data  = v.sdata;
        mem_rw_en     = v.rw_en;
        mem_rw_addr   = v.rw_addr;
        mem_pc        = 32'h0000_0400 + 32'(idx) * 32'd4;
        mem_inst      = 32'h0000_0013 ^ (32'(idx) << 7);
        if (push) begin
            e.data = v.exp_data; e.rw_en = v.exp_rw_en; e.ale = v.exp_ale; e.rw_addr = v.rw_addr;
            e.pc = mem_pc; e.inst = mem_inst; e.chk_data = v.chk_data;
            sb_q.push_back(e);
        end
    endtask

    // Runs cycles until stall_req drops, acting as the memory: grants after
    // gd refused cycles, returns data rd cycles after the grant, and throws
    // stray gnt/rvalid at the DUT while it should ignore them.
    task automatic run_cycles(input vec_t v, input string tag);
        int   stalls = 0;
        int   req_cnt = 0;
        int   rv_cnt = 0;
        logic saw_req = 1'b0;
        logic wait_rv = 1'b0;
        logic checked = 1'b0;
        logic done = 1'b0;
        logic is_ld;
        is_ld = (v.op >= 4'd1) && (v.op <= 4'd5);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            dmem.gnt    = 1'b0;
            dmem.rvalid = 1'b0;
            if (wait_rv) begin
                if (rv_cnt == v.rd) begin
                    dmem.rvalid = 1'b1;
                    dmem.rdata  = v.rdata;
                    wait_rv     = 1'b0;
                end else begin
                    dmem.gnt = 1'b1;
                end
                rv_cnt++;
            end else if (dmem.req === 1'b1) begin
                saw_req = 1'b1;
                if (!checked) begin
                    checked = 1'b1;
                    chk({tag, "_addr"}, dmem.addr, {v.ea[31:2], 2'b00});
                    chk({tag, "_we"}, 32'(dmem.we), 32'(v.exp_we));
                    if (v.exp_we) begin
                        chk({tag, "_wstrb"}, 32'(dmem.wstrb), 32'(v.exp_wstrb));
                        chk({tag, "_wdata"}, dmem.wdata, v.exp_wdata);
                    end
                end
                if (req_cnt == v.gd) begin
                    dmem.gnt = 1'b1;
                    if (is_ld) begin
                        wait_rv = 1'b1;
                        rv_cnt  = 0;
                    end
                end else begin
                    dmem.rvalid = 1'b1;
                    dmem.rdata  = 32'hDEAD_0BAD;
                end
                req_cnt++;
            end
            if (stall_req === 1'b1) begin
                stalls++;
                chk({tag, "_wb_valid_in_stall"}, 32'(wb_valid), 32'd0);
            end else begin
                done = 1'b1;
            end
        end
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got stall_req stuck high want release within 40 cycles", tag);
        end
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
        chk({tag, "_req_seen"}, 32'(saw_req), 32'(v.exp_req));
        @(posedge clk);
        #1;
    endtask

    initial begin
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata  = 32'd0;

        vecs[0]  = mk(4'd0, 32'h0000_1234, 32'd0,          1'b1, 5'd3,  0, 0, 32'd0,          32'h0000_1234, 1'b1, 1'b0, 0, 1'b0, 1'b0, 4'b0000, 32'd0,          1'b1);
        vecs[1]  = mk(4'd1, 32'h0000_1003, 32'd0,          1'b1, 5'd5,  0, 0, 32'h80FF_FF7F, 32'hFFFF_FF80, 1'b1, 1'b0, 3, 1'b1, 1'b0, 4'b0000, 32'd0,          1'b1);
        vecs[2]  = mk(4'd7, 32'h0000_2002, 32'hAAAA_BEEF, 1'b1, 5'd6,  2, 0, 32'd0,          32'd0,         1'b0, 1'b0, 4, 1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0);
        vecs[3]  = mk(4'd3, 32'h0000_3001, 32'd0,          1'b1, 5'd7,  0, 0, 32'd0,          32'd0,         1'b0, 1'b1, 0, 1'b0, 1'b0, 4'b0000, 32'd0,          1'b0);
        vecs[4]  = mk(4'd5, 32'h0000_0002, 32'd0,          1'b1, 5'd8,  0, 0, 32'h8001_0000, 32'h0000_8001, 1'b1, 1'b0, 3, 1'b1, 1'b0, 4'b0000, 32'd0,          1'b1);
        vecs[5]  = mk(4'd3, 32'h0000_0004, 32'd0,          1'b1, 5'd9,  0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 3, 1'b1, 1'b0, 4'b0000, 32'd0,          1'b1);
        vecs[6]  = mk(4'd6, 32'h0000_0041, 32'h0000_005A, 1'b1, 5'd10, 0, 0, 32'd0,          32'd0,         1'b0, 1'b0, 2, 1'b1, 1'b1, 4'b0010, 32'h5A5A_5A5A, 1'b0);
        vecs[7]  = mk(4'd8, 32'h0000_0048, 32'h1234_5678, 1'b1, 5'd11, 1, 0, 32'd0,          32'd0,         1'b0, 1'b0, 3, 1'b1, 1'b1, 4'b1111, 32'h1234_5678, 1'b0);
        vecs[8]  = mk(4'd2, 32'h0000_0052, 32'd0,          1'b1, 5'd12, 1, 2, 32'h9ABC_0000, 32'hFFFF_9ABC, 1'b1, 1'b0, 6, 1'b1, 1'b0, 4'b0000, 32'd0,          1'b1);
        vecs[9]  = mk(4'd4, 32'h0000_0061, 32'd0,          1'b1, 5'd13, 0, 1, 32'h0000_F100, 32'h0000_00F1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 4'b0000, 32'd0,          1'b1);
        vecs[10] = mk(4'd2, 32'h0000_0071, 32'd0,          1'b1, 5'd14, 0, 0, 32'd0,          32'd0,         1'b0, 1'b1, 0, 1'b0, 1'b0, 4'b0000, 32'd0,          1'b0);
        vecs[11] = mk(4'd8, 32'h0000_0082, 32'h5555_5555, 1'b1, 5'd15, 0, 0, 32'd0,          32'd0,         1'b0, 1'b1, 0, 1'b0, 1'b0, 4'b0000, 32'd0,          1'b0);
        vecs[12] = mk(4'hC, 32'h0000_0077, 32'd0,          1'b1, 5'd16, 0, 0, 32'd0,          32'h0000_0077, 1'b1, 1'b0, 0, 1'b0, 1'b0, 4'b0000, 32'd0,          1'b1);
        vecs[13] = mk(4'd1, 32'h0000_0090, 32'd0,          1'b1, 5'd17, 0, 0, 32'h1234_567F, 32'h0000_007F, 1'b1, 1'b0, 3, 1'b1, 1'b0, 4'b0000, 32'd0,          1'b1);
        vecs[14] = mk(4'd7, 32'h0000_00A0, 32'h1234_CAFE, 1'b1, 5'd18, 0, 0, 32'd0,          32'd0,         1'b0, 1'b0, 2, 1'b1, 1'b1, 4'b0011, 32'hCAFE_CAFE, 1'b0);
        vecs[15] = mk(4'd0, 32'hFFFF_FFFF, 32'd0,          1'b0, 5'd19, 0, 0, 32'd0,          32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4'b0000, 32'd0,          1'b1);

        // Reset: outputs held low even with ops that would otherwise drive them.
        drive(vecs[3], 100, 1'b0);
        @(negedge clk);
        chk("rst_ale", 32'(ale), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rw_en", 32'(wb_rw_en), 32'd0);
        @(posedge clk);
        #1;
        drive(vecs[5], 101, 1'b0);
        @(negedge clk);
        chk("rst_stall_req", 32'(stall_req), 32'd0);
        chk("rst_dmem_req", 32'(dmem.req), 32'd0);
        chk("rst_dmem_we", 32'(dmem.we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i], i, 1'b1);
            run_cycles(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while waiting for load data; a late rvalid must be ignored.
        vr = mk(4'd3, 32'h0000_0100, 32'd0, 1'b1, 5'd20, 0, 0, 32'h1122_3344, 32'h1122_3344,
                1'b1, 1'b0, 2, 1'b1, 1'b0, 4'b0000, 32'd0, 1'b1);
        drive(vr, 200, 1'b0);
        @(negedge clk);
        chk("rw_idle_stall", 32'(stall_req), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rw_req", 32'(dmem.req), 32'd1);
        dmem.gnt = 1'b1;
        @(posedge clk);
        #1;
        dmem.gnt = 1'b0;
        @(negedge clk);
        chk("rw_wait_stall", 32'(stall_req), 32'd1);
        chk("rw_wait_no_req", 32'(dmem.req), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("rw_rst_stall", 32'(stall_req), 32'd0);
        chk("rw_rst_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("rw_after_idle_stall", 32'(stall_req), 32'd1);
        chk("rw_after_no_req", 32'(dmem.req), 32'd0);
        chk("rw_after_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
        dmem.rvalid = 1'b0;
        drive(vr, 200, 1'b1);
        run_cycles(vr, "rw_retry");

        chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Consumes the EX/MEM record: inst, pc, ex_result, rw_en, rw_addr, lsu_data, lsu_op.
- For load/store ops it runs a request/grant/response transaction on the data-memory port, aligns and extends load data, and stalls the pipeline until the access completes.
- Non-memory ops pass ex_result straight through with no added latency.

Parameters:
- DATA_W, 32, datapath and memory data width.
- ADDR_W, 32, address width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset; rst==`RST_VALID (1) resets on the rising edge of clk.
- mem_inst  in  32  instruction from EX/MEM.
- mem_pc  in  ADDR_W  pc from EX/MEM.
- mem_ex_result  in  DATA_W  ALU result; effective address for load/store.
- mem_rw_en  in  1  register writeback enable.
- mem_rw_addr  in  REG_AW  writeback register.
- mem_lsu_data  in  DATA_W  store data.
- mem_lsu_op  in  4  lsu_op_t code.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address ({ea[31:2],2'b00}).
- dmem_wstrb  out  4  byte strobes.
- dmem_wdata  out  DATA_W  lane-replicated store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  DATA_W  load data.
- wb_valid  out  1  record below is valid for MEM/WB this cycle.
- wb_inst  out  32  forwarded instruction.
- wb_pc  out  ADDR_W  forwarded pc.
- wb_rw_en  out  1  writeback enable.
- wb_rw_addr  out  REG_AW  writeback register.
- wb_rw_data  out  DATA_W  writeback data.
- stall_req  out  1  hold EX/MEM and earlier stages.
- ale  out  1  address-misalignment exception flag for the current op.

Behaviour:
- State machine, one registered state: IDLE, REQ, WAIT, DONE.
- Reset:
  - state=IDLE and the load-data register = 0.
  - While rst=1, stall_req, dmem_req, dmem_we, wb_valid, wb_rw_en and ale are all 0.
- Input contract: EX/MEM holds its inputs stable while stall_req=1.
- Op classification:
  - is_mem = lsu_op != LSU_OP_NONE.
  - misaligned = (half op && ea[0]) || (word op && ea[1:0]!=0).
- Non-mem op or LSU_OP_NONE in IDLE:
  - wb_valid=1, wb_rw_data=mem_ex_result, stall_req=0.
  - Same-cycle combinational passthrough.
- Misaligned mem op in IDLE:
  - No dmem request, ale=1, wb_rw_en=0, wb_valid=1, stall_req=0.
  - Exception is carried to WB.
- Aligned mem op, transitions:
  - IDLE -> REQ.
  - REQ: dmem_req=1. On gnt, a store goes to DONE and a load goes to WAIT; without gnt, stay in REQ.
  - WAIT: on rvalid, capture dmem_rdata and go to DONE; otherwise stay.
  - DONE -> IDLE unconditionally.
- Aligned mem op, outputs:
  - stall_req=1 in IDLE (with an aligned mem op), REQ and WAIT; stall_req=0 in DONE.
  - wb_valid=0 while stall_req=1; wb_valid=1 in DONE.
- Latency with gnt and rvalid both immediate:
  - Store: 2 stall cycles.
  - Load: 3 stall cycles.
  - The record is presented once, in DONE.
- Back-to-back mem ops: the next instruction arrives while in IDLE after DONE and starts a fresh transaction. No overlap.
- dmem_rvalid outside WAIT is ignored.
- dmem_gnt outside REQ is ignored.
- Store lanes:
  - ST_B: wstrb = 4'b0001<<ea[1:0]; wdata = {4{data[7:0]}}.
  - ST_H: wstrb = 4'b0011<<ea[1:0]; wdata = {2{data[15:0]}}.
  - ST_W: wstrb = 4'b1111; wdata = data.
  - Stores force wb_rw_en=0.
- Load extraction:
  - sh = rdata_q >> (ea[1:0]*8).
  - LD_B sign-extends sh[7:0]; LD_BU zero-extends sh[7:0].
  - LD_H sign-extends sh[15:0]; LD_HU zero-extends sh[15:0].
  - LD_W passes rdata_q.
- Unknown lsu_op codes are treated as LSU_OP_NONE.
- Reset mid-transaction: return to IDLE and drop the outstanding access. Any late rvalid is ignored because state≠WAIT.

Decomposition:
- Shared package entries:
  - lsu_op_t (4-bit): NONE=0, LD_B=1, LD_H=2, LD_W=3, LD_BU=4, LD_HU=5, ST_B=6, ST_H=7, ST_W=8. LSU_OP_INVALID aliases NONE.
  - mem_state_t.
  - Helper functions is_load and is_store.
- Sub-module lsu_align: purely combinational store-lane generation and load extract/extend, unit-testable on its own.

Test Plan:
- ALU op, ex_result=0x1234, rw_en=1, rw_addr=3 -> same cycle wb_valid=1, wb_rw_data=0x1234, stall_req=0, dmem_req=0.
- LD_B ea=0x1003, rdata=0x80FF_FF7F, gnt immediate, rvalid 1 cycle later -> stall_req=1 for 3 cycles; in DONE wb_rw_data=0xFFFF_FF80, dmem_addr=0x1000.
- ST_H ea=0x2002, lsu_data=0xAAAA_BEEF, gnt held low 2 cycles -> wstrb=1100, wdata=0xBEEF_BEEF, dmem_we=1; 4 stall cycles; wb_rw_en=0.
- LD_W ea=0x3001 -> ale=1, dmem_req never asserted, stall_req=0, wb_rw_en=0.
- LD_HU ea=0x0002, rdata=0x8001_0000, followed back-to-back by LD_W -> first result 0x0000_8001; second transaction starts the cycle after DONE.
- rst asserted in WAIT, with rvalid arriving the cycle after rst drops -> state IDLE, no wb_valid, stray rvalid ignored.
